cbfp_0: RTL and testbench



---
 rtl/cbfp_pkg.sv | 29 ++
 rtl/cbfp_lsb_cnt.sv | 18 +
 rtl/cbfp_0.sv | 113 +++++++++++
 tb/tb_cbfp_0.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/cbfp_pkg.sv
// Shared constants, types and helpers for the stage-0 CBFP normaliser.
package cbfp_pkg;
  localparam int IN_W            = 23;
  localparam int OUT_W           = 11;
  localparam int LANES           = 16;
  localparam int BEATS_PER_FRAME = 32;
  localparam int BEATS_PER_BLK   = 2;
  localparam int MAX_SHIFT       = 12;
  localparam int NSAMP           = 4 * LANES;
  localparam int IDX_W           = 5;

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic {IDLE, RUN} state_e;

  // Block shift: the smaller of the two beat minima, clamped to MAX_SHIFT.
  function automatic idx_t clamp_shift(input idx_t a, input idx_t b);
    idx_t m;
    m = (a < b) ? a : b;
    return (m > idx_t'(MAX_SHIFT)) ? idx_t'(MAX_SHIFT) : m;
  endfunction

  // The shift never exceeds the redundant sign bits, so plain truncation is exact.
  function automatic logic [OUT_W-1:0] norm(input logic [IN_W-1:0] x, input idx_t s);
    logic [IN_W-1:0] t;
    t = x << s;
    return t[IN_W-1 -: OUT_W];
  endfunction
endpackage

// File: rtl/cbfp_lsb_cnt.sv
// Counts the bits directly below the MSB that repeat the sign bit (0..IN_W-1).
module cbfp_lsb_cnt
  import cbfp_pkg::*;
(
  input  logic [IN_W-1:0]  x_i,
  output logic [IDX_W-1:0] cnt_o
);
  logic run;

  always_comb begin
    cnt_o = '0;
    run   = 1'b1;
    for (int i = IN_W-2; i >= 0; i--) begin
      if (run && (x_i[i] == x_i[IN_W-1])) cnt_o = cnt_o + 1'b1;
      else                                 run   = 1'b0;
    end
  end
endmodule

// File: rtl/cbfp_0.sv
// Stage-0 CBFP normaliser: per 2-beat block, finds the common sign-bit headroom,
// shifts every sample left by it (clamped) and emits the shift index with the data.
module cbfp_0
  import cbfp_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              alert_CBFP,
  input  logic [IN_W-1:0]   din_R_add [0:LANES-1],
  input  logic [IN_W-1:0]   din_Q_add [0:LANES-1],
  input  logic [IN_W-1:0]   din_R_sub [0:LANES-1],
  input  logic [IN_W-1:0]   din_Q_sub [0:LANES-1],
  output logic [OUT_W-1:0]  dout_R_add [0:LANES-1],
  output logic [OUT_W-1:0]  dout_Q_add [0:LANES-1],
  output logic [OUT_W-1:0]  dout_R_sub [0:LANES-1],
  output logic [OUT_W-1:0]  dout_Q_sub [0:LANES-1],
  output logic              dout_valid,
  output logic [IDX_W-1:0]  cbfp_index,
  output logic              alert_next
);
  state_e           state_q;
  logic [4:0]       beat_q;
  logic [4:0]       beat_cur;
  logic             accept, beat_odd;
  logic             v1_q, odd1_q, first1_q;
  idx_t             min1_q, s_q, s_d, s_use, beat_min;
  logic [IN_W-1:0]  din_all [0:NSAMP-1];
  logic [IN_W-1:0]  d1_q    [0:NSAMP-1];
  logic [OUT_W-1:0] dout_q  [0:NSAMP-1];
  idx_t             cnt     [0:NSAMP-1];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign din_all[l]         = din_R_add[l];
    assign din_all[LANES+l]   = din_Q_add[l];
    assign din_all[2*LANES+l] = din_R_sub[l];
    assign din_all[3*LANES+l] = din_Q_sub[l];
    assign dout_R_add[l]      = dout_q[l];
    assign dout_Q_add[l]      = dout_q[LANES+l];
    assign dout_R_sub[l]      = dout_q[2*LANES+l];
    assign dout_Q_sub[l]      = dout_q[3*LANES+l];
  end

  for (genvar n = 0; n < NSAMP; n++) begin : g_cnt
    cbfp_lsb_cnt u_cnt (.x_i(din_all[n]), .cnt_o(cnt[n]));
  end

  always_comb begin
    beat_min = idx_t'(IN_W-1);
    for (int n = 0; n < NSAMP; n++) begin
      if (cnt[n] < beat_min) beat_min = cnt[n];
    end
  end

  assign accept   = (state_q == RUN) || alert_CBFP;
  assign beat_cur = (state_q == RUN) ? beat_q : 5'd0;
  assign beat_odd = (beat_cur % 5'(BEATS_PER_BLK)) != 5'd0;

  // While the even beat sits in d1, the odd beat is on the inputs: the block
  // shift is known combinationally and also captured in s_q for the odd beat.
  assign s_d   = clamp_shift(min1_q, beat_min);
  assign s_use = odd1_q ? s_q : s_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      v1_q       <= 1'b0;
      odd1_q     <= 1'b0;
      first1_q   <= 1'b0;
      min1_q     <= '0;
      s_q        <= '0;
      dout_valid <= 1'b0;
      alert_next <= 1'b0;
      cbfp_index <= '0;
    end else begin
      case (state_q)
        IDLE: if (alert_CBFP) begin
          state_q <= RUN;
          beat_q  <= 5'd1;
        end
        RUN: if (beat_q == 5'(BEATS_PER_FRAME-1)) begin
          state_q <= IDLE;
          beat_q  <= '0;
        end else begin
          beat_q  <= beat_q + 5'd1;
        end
        default: state_q <= IDLE;
      endcase
      v1_q       <= accept;
      odd1_q     <= beat_odd;
      first1_q   <= accept && (beat_cur == 5'd0);
      min1_q     <= beat_min;
      if (accept && beat_odd) s_q <= s_d;
      dout_valid <= v1_q;
      alert_next <= v1_q && first1_q;
      if (v1_q && !odd1_q) cbfp_index <= s_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int n = 0; n < NSAMP; n++) begin
        d1_q[n]   <= '0;
        dout_q[n] <= '0;
      end
    end else begin
      for (int n = 0; n < NSAMP; n++) begin
        if (accept) d1_q[n]   <= din_all[n];
        if (v1_q)   dout_q[n] <= norm(d1_q[n], s_use);
      end
    end
  end
endmodule

// File: tb/tb_cbfp_0.sv
// Directed self-checking bench for the stage-0 CBFP normaliser.
module tb_cbfp_0;
  logic        clk, rstn, alert_CBFP;
  logic [22:0] din_R_add [0:15];
  logic [22:0] din_Q_add [0:15];
  logic [22:0] din_R_sub [0:15];
  logic [22:0] din_Q_sub [0:15];
  logic [10:0] dout_R_add [0:15];
  logic [10:0] dout_Q_add [0:15];
  logic [10:0] dout_R_sub [0:15];
  logic [10:0] dout_Q_sub [0:15];
  logic        dout_valid, alert_next;
  logic [4:0]  cbfp_index;

  int errors = 0;
  int checks = 0;

  cbfp_0 dut (
    .clk(clk), .rstn(rstn), .alert_CBFP(alert_CBFP),
    .din_R_add(din_R_add), .din_Q_add(din_Q_add),
    .din_R_sub(din_R_sub), .din_Q_sub(din_Q_sub),
    .dout_R_add(dout_R_add), .dout_Q_add(dout_Q_add),
    .dout_R_sub(dout_R_sub), .dout_Q_sub(dout_Q_sub),
    .dout_valid(dout_valid), .cbfp_index(cbfp_index), .alert_next(alert_next)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pattern ids: 0 all +1024, 1 one full-scale sample in beat 0, 2 zeros,
  // 3 all +1, 4 block 1 at +65536 and the rest +1024.
  function automatic logic [22:0] stim(input int id, input int b, input int n);
    case (id)
      0:       return 23'd1024;
      1:       return (b == 0 && n == 0) ? 23'h400000 : 23'd1024;
      2:       return 23'd0;
      3:       return 23'd1;
      default: return (b == 2 || b == 3) ? 23'd65536 : 23'd1024;
    endcase
  endfunction

  function automatic logic [4:0] exp_idx(input int id, input int blk);
    case (id)
      0:       return 5'd11;
      1:       return (blk == 0) ? 5'd0 : 5'd11;
      2, 3:    return 5'd12;
      default: return (blk == 1) ? 5'd5 : 5'd11;
    endcase
  endfunction

  function automatic logic [10:0] exp_out(input int id, input int b, input int n);
    case (id)
      1:       return (b >= 2) ? 11'd512 : ((b == 0 && n == 0) ? 11'h400 : 11'd0);
      2:       return 11'd0;
      3:       return 11'd1;
      default: return 11'd512;
    endcase
  endfunction

  task automatic drive(input int id, input int b, input logic alert);
    alert_CBFP = alert;
    for (int l = 0; l < 16; l++) begin
      din_R_add[l] = stim(id, b, l);
      din_Q_add[l] = stim(id, b, 16 + l);
      din_R_sub[l] = stim(id, b, 32 + l);
      din_Q_sub[l] = stim(id, b, 48 + l);
    end
  endtask

  task automatic drive_idle();
    alert_CBFP = 1'b0;
    for (int l = 0; l < 16; l++) begin
      din_R_add[l] = '0; din_Q_add[l] = '0; din_R_sub[l] = '0; din_Q_sub[l] = '0;
    end
  endtask

  // Drives nfr consecutive frames and checks each output beat two cycles later.
  task automatic run_stream(input string tag, input int id0, input int id1,
                            input int nfr, input int stray_at);
    int total, ob, f, b, id, bad_n;
    logic [10:0] act, expv;
    total = nfr * 32;
    for (int k = 0; k <= total + 2; k++) begin
      @(negedge clk);
      if (k == 1 || k == total + 2) begin
        checks++;
        if (dout_valid !== 1'b0) begin
          errors++;
          $display("FAIL %s valid_idle k=%0d got=%b want=0", tag, k, dout_valid);
        end
      end else if (k >= 2) begin
        ob = k - 2; f = ob / 32; b = ob % 32; id = (f == 0) ? id0 : id1;
        checks++;
        if (dout_valid !== 1'b1) begin
          errors++;
          $display("FAIL %s valid f=%0d beat=%0d got=%b want=1", tag, f, b, dout_valid);
        end
        checks++;
        if (alert_next !== (b == 0)) begin
          errors++;
          $display("FAIL %s alert_next f=%0d beat=%0d got=%b want=%b", tag, f, b, alert_next, b == 0);
        end
        checks++;
        if (cbfp_index !== exp_idx(id, b / 2)) begin
          errors++;
          $display("FAIL %s index f=%0d beat=%0d got=%0d want=%0d", tag, f, b, cbfp_index, exp_idx(id, b / 2));
        end
        bad_n = -1; act = '0; expv = '0;
        for (int l = 0; l < 16 && bad_n < 0; l++) begin
          if (dout_R_add[l] !== exp_out(id, b, l))      begin bad_n = l;      act = dout_R_add[l]; expv = exp_out(id, b, l);      end
          else if (dout_Q_add[l] !== exp_out(id, b, 16+l)) begin bad_n = 16+l; act = dout_Q_add[l]; expv = exp_out(id, b, 16+l); end
          else if (dout_R_sub[l] !== exp_out(id, b, 32+l)) begin bad_n = 32+l; act = dout_R_sub[l]; expv = exp_out(id, b, 32+l); end
          else if (dout_Q_sub[l] !== exp_out(id, b, 48+l)) begin bad_n = 48+l; act = dout_Q_sub[l]; expv = exp_out(id, b, 48+l); end
        end
        checks++;
        if (bad_n >= 0) begin
          errors++;
          $display("FAIL %s data f=%0d beat=%0d sample=%0d got=%h want=%h", tag, f, b, bad_n, act, expv);
        end
      end
      if (k < total) drive((k / 32 == 0) ? id0 : id1, k % 32, (k % 32 == 0) || (k == stray_at));
      else           drive_idle();
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    int nz;
    nz = 0;
    for (int l = 0; l < 16; l++)
      if (dout_R_add[l] !== 0 || dout_Q_add[l] !== 0 || dout_R_sub[l] !== 0 || dout_Q_sub[l] !== 0) nz++;
    checks++;
    if (dout_valid !== 1'b0 || alert_next !== 1'b0 || cbfp_index !== 5'd0 || nz != 0) begin
      errors++;
      $display("FAIL %s got valid=%b alert_next=%b index=%0d nonzero_lanes=%0d want all 0",
               tag, dout_valid, alert_next, cbfp_index, nz);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    drive_idle();
    #2;
    check_outputs_zero("reset");
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_scaling();     run_stream("scaling", 0, 0, 1, -1); endtask
  task automatic test_full_scale();  run_stream("full_scale", 1, 1, 1, -1); endtask
  task automatic test_clamp();
    run_stream("clamp_zero", 2, 2, 1, -1);
    run_stream("clamp_one", 3, 3, 1, -1);
  endtask
  task automatic test_per_block();   run_stream("per_block", 4, 4, 1, -1); endtask
  task automatic test_back_to_back(); run_stream("back_to_back", 0, 4, 2, -1); endtask
  task automatic test_stray_alert(); run_stream("stray_alert", 0, 0, 1, 10); endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      drive(0, k, k == 0);
    end
    @(negedge clk);
    rstn = 1'b0;
    drive_idle();
    #1;
    check_outputs_zero("reset_mid");
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (6) begin
      @(negedge clk);
      checks++;
      if (dout_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_no_partial got valid=%b want=0", dout_valid);
      end
    end
    run_stream("after_reset", 0, 0, 1, -1);
  endtask

  initial begin
    test_reset();
    test_scaling();
    test_full_scale();
    test_clamp();
    test_per_block();
    test_back_to_back();
    test_stray_alert();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
